// File: rtl/mux_n_reg.sv
// mux_n_reg: registered N-channel multiplexer with a DIRECT mode (follow one
// channel) and a SCAN mode (rotate through enabled channels with a dwell gap).
// All outputs come straight from flops; in_bus only ever reaches out through
// the capture register.
`timescale 1ns/1ps

module mux_n_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DWELL_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]          select,
    input  logic                      sel_load,
    input  logic                      mode,
    input  logic [DWELL_W-1:0]        dwell,
    input  logic [CHANNELS-1:0]       en_mask,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out,
    output logic                      out_valid,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      sel_err
);

    localparam int SLOTS = 2**SEL_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     out_q;
    logic                 out_valid_q;
    logic [SEL_W-1:0]     cur_sel_q;
    logic                 sel_err_q;
    logic [DWELL_W-1:0]   dwell_cnt_q;
    logic [DWELL_W-1:0]   dwell_lat_q;

    // Channel view padded to the full select range so any cur_sel value
    // indexes a defined entry (unused slots read as zero).
    logic [WIDTH-1:0]     chan_data [SLOTS];

    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_chan
            if (gi < CHANNELS) begin : g_real
                assign chan_data[gi] = in_bus[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign chan_data[gi] = '0;
            end
        end
    endgenerate

    logic                 slot_open;
    logic                 select_ok;
    logic [SEL_W-1:0]     scan_sel_d;
    logic [SEL_W-1:0]     lo_any;
    logic [SEL_W-1:0]     lo_above;
    logic                 any_en;
    logic                 above_en;

    assign slot_open = !out_valid_q || out_ready;
    assign select_ok = (int'(select) < CHANNELS);

    // Next SCAN channel: lowest enabled index above cur_sel, else wrap to the
    // lowest enabled index overall (which is cur_sel itself if it is alone).
    always_comb begin
        lo_any     = '0;
        lo_above   = '0;
        any_en     = 1'b0;
        above_en   = 1'b0;
        scan_sel_d = cur_sel_q;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (en_mask[k]) begin
                lo_any = SEL_W'(k);
                any_en = 1'b1;
                if (k > int'(cur_sel_q)) begin
                    lo_above = SEL_W'(k);
                    above_en = 1'b1;
                end
            end
        end
        if (above_en) begin
            scan_sel_d = lo_above;
        end else if (any_en) begin
            scan_sel_d = lo_any;
        end
    end

    // Mode FSM and output registers: load handling takes priority over the
    // per-state capture logic; a load cycle never captures.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            cur_sel_q   <= '0;
            sel_err_q   <= 1'b0;
            dwell_cnt_q <= '0;
            dwell_lat_q <= '0;
        end else begin
            sel_err_q <= 1'b0;
            if (sel_load) begin
                // Consumer may still drain the held sample during a load.
                if (out_ready) begin
                    out_valid_q <= 1'b0;
                end
                if (select_ok) begin
                    cur_sel_q   <= select;
                    dwell_cnt_q <= dwell;
                    dwell_lat_q <= dwell;
                    state_q     <= mode ? ST_SCAN : ST_DIRECT;
                end else begin
                    sel_err_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (slot_open) begin
                            out_valid_q <= 1'b0;
                        end
                    end
                    ST_DIRECT: begin
                        if (slot_open) begin
                            out_q       <= chan_data[cur_sel_q];
                            out_valid_q <= 1'b1;
                        end
                    end
                    ST_SCAN: begin
                        if (dwell_cnt_q != '0) begin
                            dwell_cnt_q <= dwell_cnt_q - 1'b1;
                            if (slot_open) begin
                                out_valid_q <= 1'b0;
                            end
                        end else if (slot_open) begin
                            // Capture the current channel even if its mask
                            // bit is clear; the mask only steers the advance.
                            out_q       <= chan_data[cur_sel_q];
                            out_valid_q <= 1'b1;
                            dwell_cnt_q <= dwell_lat_q;
                            cur_sel_q   <= scan_sel_d;
                            sel_err_q   <= !any_en;
                        end
                        // Slot closed at dwell end: stall with everything held.
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign cur_sel   = cur_sel_q;
    assign sel_err   = sel_err_q;

endmodule
